// File: rtl/folded_fir_tap_sequencer.sv
// folded_fir_tap_sequencer: keeps the TAPS-deep sample delay line and issues one
// (sample, coefficient) pair per fast-clock cycle to a shared folded MAC.
module folded_fir_tap_sequencer #(
    parameter int DATA_W = 10,
    parameter int COEF_W = 12,
    parameter int TAPS   = 5
) (
    input  logic                     clk100,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [TAPS*COEF_W-1:0]   coef_flat,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     mac_valid,
    output logic [DATA_W-1:0]        mac_x,
    output logic [COEF_W-1:0]        mac_c,
    output logic                     mac_first,
    output logic                     mac_last
);
    localparam int PW = $clog2(TAPS);
    localparam logic [PW-1:0] LAST = PW'(TAPS - 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [DATA_W-1:0]   x_q [TAPS];
    logic [DATA_W-1:0]   x_d [TAPS];
    logic [COEF_W-1:0]   c_q [TAPS];
    logic [COEF_W-1:0]   c_d [TAPS];
    logic [DATA_W-1:0]   sel_x;
    logic [COEF_W-1:0]   sel_c;
    logic                valid_q, first_q, last_q;
    logic [DATA_W-1:0]   mx_q;
    logic [COEF_W-1:0]   mc_q;
    logic                accept;
    assign in_ready  = !rst && !flush && (state_q == IDLE || (state_q == RUN && phase_q == LAST));
    assign accept    = in_valid && in_ready;
    assign mac_valid = valid_q;
    assign mac_x     = mx_q;
    assign mac_c     = mc_q;
    assign mac_first = first_q;
    assign mac_last  = last_q;
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        x_d     = x_q;
        c_d     = c_q;
        if (flush) begin
            state_d = IDLE;
            phase_d = '0;
            for (int k = 0; k < TAPS; k++) x_d[k] = '0;
        end else if (accept) begin
            state_d = RUN;
            phase_d = '0;
            x_d[0]  = in_data;
            for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
            for (int k = 0; k < TAPS; k++) c_d[k] = coef_flat[k*COEF_W +: COEF_W];
        end else if (state_q == RUN) begin
            state_d = (phase_q == LAST) ? IDLE : RUN;
            phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
        end
        // Outputs are registered from next-state so phase p shows during phase p.
        sel_x = '0;
        sel_c = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (phase_d == PW'(k)) begin
                sel_x = x_d[k];
                sel_c = c_d[k];
            end
        end
    end
    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            mx_q    <= '0;
            mc_q    <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            x_q     <= x_d;
            c_q     <= c_d;
            valid_q <= state_d == RUN;
            first_q <= state_d == RUN && phase_d == '0;
            last_q  <= state_d == RUN && phase_d == LAST;
            if (state_d == RUN) begin
                mx_q <= sel_x;
                mc_q <= sel_c;
            end
        end
    end
endmodule
